// File: rtl/tick_gen_ctl.sv
// ---------------------------------------------------------------------------
// tick_gen_ctl
//   Clock-enable generator for the mod-20 counter stages. Divides CLK by a
//   runtime-programmable divisor and emits one-cycle TICK pulses. A start/stop
//   FSM gates counting, and a req/ack handshake loads a new divisor into a
//   shadow register. The shadow is applied only at a terminal count, so every
//   tick period is a whole period of either the old or the new divisor.
//
//   Optional build macro: TICK_GEN_CTL_STEP_EN
//     Adds the STEP input. In IDLE, with START and STOP both low, each edge
//     that samples STEP=1 produces one TICK cycle.
//
// Ports
//   CLK      in   clock
//   RST      in   synchronous reset, active-low
//   START    in   level, IDLE -> RUN (STOP has priority)
//   STOP     in   level, RUN -> IDLE
//   STEP     in   single-step tick request in IDLE (macro builds only)
//   DIV_LD   in   divisor load request (level)
//   DIV_IN   in   requested divisor, held stable while DIV_LD=1
//   DIV_ACK  out  one-cycle pulse, DIV_IN captured into the shadow
//   TICK     out  registered one-cycle enable pulse
//   RUNNING  out  high in RUN
//   PRE      out  current prescaler count
//   DIV_CUR  out  active divisor
// ---------------------------------------------------------------------------
// state  | meaning
// -------+-------------------------------------------------
// S_IDLE | stopped; PRE held at 0, pending divisor applied at once
// S_RUN  | counting; TICK on PRE==DIV_CUR-1, divisor applied at wrap
// ---------------------------------------------------------------------------
module tick_gen_ctl #(
  parameter int WIDTH       = 16,
  parameter int DIV_DEFAULT = 50000,
  parameter int MIN_DIV     = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
`ifdef TICK_GEN_CTL_STEP_EN
  input  logic             STEP,
`endif
  input  logic             DIV_LD,
  input  logic [WIDTH-1:0] DIV_IN,
  output logic             DIV_ACK,
  output logic             TICK,
  output logic             RUNNING,
  output logic [WIDTH-1:0] PRE,
  output logic [WIDTH-1:0] DIV_CUR
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] shadow;
  logic             pending;
  logic             wrap;
  logic             accept;
  logic             apply;
  logic             step_fire;
  logic [WIDTH-1:0] div_clamped;

  // PRE never exceeds DIV_CUR-1 and DIV_CUR >= 2, so the subtraction is safe.
  assign wrap        = (state_q == S_RUN) && (PRE == (DIV_CUR - ONE));
  // The DIV_ACK term keeps a still-high DIV_LD from being taken twice.
  assign accept      = DIV_LD && !pending && !DIV_ACK;
  // pending is 0 on any accepting edge, so accept and apply never coincide.
  assign apply       = pending && ((state_q == S_IDLE) || wrap);
  assign div_clamped = (DIV_IN < MIN_V) ? MIN_V : DIV_IN;

`ifdef TICK_GEN_CTL_STEP_EN
  assign step_fire = (state_q == S_IDLE) && STEP && !START && !STOP;
`else
  assign step_fire = 1'b0;
`endif

  // -- FSM: state register ----------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // -- FSM: next state --------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START && !STOP) state_d = S_RUN;
      S_RUN:   if (STOP)           state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -- FSM: outputs -----------------------------------------------------------
  always_comb begin
    RUNNING = (state_q == S_RUN);
  end

  // -- Prescaler and tick -----------------------------------------------------
  // Any edge that is not a plain RUN count (IDLE, START edge, STOP edge)
  // forces PRE to 0; only a single-step can raise TICK outside RUN.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      PRE  <= '0;
      TICK <= 1'b0;
    end else if ((state_q == S_RUN) && !STOP) begin
      if (wrap) begin
        PRE  <= '0;
        TICK <= 1'b1;
      end else begin
        PRE  <= PRE + ONE;
        TICK <= 1'b0;
      end
    end else begin
      PRE  <= '0;
      TICK <= step_fire;
    end
  end

  // -- Divisor load handshake and apply ---------------------------------------
  always_ff @(posedge CLK) begin
    if (!RST) begin
      shadow  <= DIV_RST;
      DIV_CUR <= DIV_RST;
      pending <= 1'b0;
      DIV_ACK <= 1'b0;
    end else begin
      DIV_ACK <= accept;
      if (accept) begin
        shadow  <= div_clamped;
        pending <= 1'b1;
      end else if (apply) begin
        DIV_CUR <= shadow;
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tick_gen_ctl.sv
// ---------------------------------------------------------------------------
// tb_tick_gen_ctl
//   Self-checking bench for tick_gen_ctl. Each scenario task pushes the
//   per-cycle expected outputs to a scoreboard queue as it drives stimulus,
//   then pops and compares them cycle by cycle. Outputs are sampled 1 ns
//   after the rising edge. Build with TICK_GEN_CTL_STEP_EN to cover STEP.
// ---------------------------------------------------------------------------
module tb_tick_gen_ctl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        STOP;
`ifdef TICK_GEN_CTL_STEP_EN
  logic        STEP;
`endif
  logic        DIV_LD;
  logic [15:0] DIV_IN;
  logic        DIV_ACK;
  logic        TICK;
  logic        RUNNING;
  logic [15:0] PRE;
  logic [15:0] DIV_CUR;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        tick;
    logic [15:0] pre;
    logic        ack;
    logic [15:0] divc;
  } exp_t;

  exp_t sb[$];

  tick_gen_ctl dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .STOP    (STOP),
`ifdef TICK_GEN_CTL_STEP_EN
    .STEP    (STEP),
`endif
    .DIV_LD  (DIV_LD),
    .DIV_IN  (DIV_IN),
    .DIV_ACK (DIV_ACK),
    .TICK    (TICK),
    .RUNNING (RUNNING),
    .PRE     (PRE),
    .DIV_CUR (DIV_CUR)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    cyc();
    cyc();
    RST = 1'b1;
    n_checks++; if (DIV_CUR !== 16'd50000) begin n_fail++; $display("FAIL reset_div_cur: got %0d want 50000", DIV_CUR); end
    n_checks++; if (PRE !== 16'd0)         begin n_fail++; $display("FAIL reset_pre: got %0d want 0", PRE); end
    n_checks++; if (TICK !== 1'b0)         begin n_fail++; $display("FAIL reset_tick: got %b want 0", TICK); end
    n_checks++; if (RUNNING !== 1'b0)      begin n_fail++; $display("FAIL reset_running: got %b want 0", RUNNING); end
    n_checks++; if (DIV_ACK !== 1'b0)      begin n_fail++; $display("FAIL reset_ack: got %b want 0", DIV_ACK); end
  endtask

  // Load in IDLE: ACK right after the sampling edge, DIV_CUR one edge later.
  task automatic test_load(input logic [15:0] v, input logic [15:0] exp_new, input logic [15:0] exp_old);
    DIV_LD = 1'b1;
    DIV_IN = v;
    cyc();
    n_checks++; if (DIV_ACK !== 1'b1)  begin n_fail++; $display("FAIL load_ack(%0d): got %b want 1", v, DIV_ACK); end
    n_checks++; if (DIV_CUR !== exp_old) begin n_fail++; $display("FAIL load_div_early(%0d): got %0d want %0d", v, DIV_CUR, exp_old); end
    DIV_LD = 1'b0;
    cyc();
    n_checks++; if (DIV_ACK !== 1'b0)  begin n_fail++; $display("FAIL load_ack_len(%0d): got %b want 0", v, DIV_ACK); end
    n_checks++; if (DIV_CUR !== exp_new) begin n_fail++; $display("FAIL load_div(%0d): got %0d want %0d", v, DIV_CUR, exp_new); end
  endtask

  // Start from IDLE with DIV_CUR==div; START stays high in RUN and must be ignored.
  task automatic test_run(input int div, input int periods);
    exp_t e;
    int   k;
    START = 1'b1;
    cyc();
    n_checks++; if (RUNNING !== 1'b1) begin n_fail++; $display("FAIL run_running: got %b want 1", RUNNING); end
    n_checks++; if (PRE !== 16'd0)    begin n_fail++; $display("FAIL run_start_pre: got %0d want 0", PRE); end
    n_checks++; if (TICK !== 1'b0)    begin n_fail++; $display("FAIL run_start_tick: got %b want 0", TICK); end
    for (int i = 1; i <= div * periods; i++) begin
      e.pre  = 16'(i % div);
      e.tick = ((i % div) == 0);
      e.ack  = 1'b0;
      e.divc = 16'(div);
      sb.push_back(e);
    end
    k = 1;
    while (sb.size() > 0) begin
      cyc();
      e = sb.pop_front();
      n_checks++; if (TICK !== e.tick) begin n_fail++; $display("FAIL run_tick(div=%0d,cyc=%0d): got %b want %b", div, k, TICK, e.tick); end
      n_checks++; if (PRE !== e.pre)   begin n_fail++; $display("FAIL run_pre(div=%0d,cyc=%0d): got %0d want %0d", div, k, PRE, e.pre); end
      k++;
    end
    START = 1'b0;
  endtask

  // Continues from the end of test_run(5,..): load 3 at PRE=1, then a
  // second request (7) that must stall until the wrap applies 3.
  task automatic test_load_in_run();
    exp_t        e;
    logic [15:0] pre_t[21]  = '{2,3,4,0,1,2,0,1,2,3,4,5,6,0,1,2,3,4,5,6,0};
    logic        tick_t[21] = '{0,0,0,1,0,0,1,0,0,0,0,0,0,1,0,0,0,0,0,0,1};
    logic        ack_t[21]  = '{1,0,0,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    logic [15:0] div_t[21]  = '{5,5,5,3,3,3,7,7,7,7,7,7,7,7,7,7,7,7,7,7,7};
    cyc();
    n_checks++; if (PRE !== 16'd1) begin n_fail++; $display("FAIL lrun_pre1: got %0d want 1", PRE); end
    for (int i = 0; i < 21; i++) begin
      e.pre = pre_t[i]; e.tick = tick_t[i]; e.ack = ack_t[i]; e.divc = div_t[i];
      sb.push_back(e);
    end
    DIV_LD = 1'b1;
    DIV_IN = 16'd3;
    for (int i = 0; i < 21; i++) begin
      cyc();
      e = sb.pop_front();
      n_checks++; if (TICK !== e.tick)    begin n_fail++; $display("FAIL lrun_tick(%0d): got %b want %b", i, TICK, e.tick); end
      n_checks++; if (PRE !== e.pre)      begin n_fail++; $display("FAIL lrun_pre(%0d): got %0d want %0d", i, PRE, e.pre); end
      n_checks++; if (DIV_ACK !== e.ack)  begin n_fail++; $display("FAIL lrun_ack(%0d): got %b want %b", i, DIV_ACK, e.ack); end
      n_checks++; if (DIV_CUR !== e.divc) begin n_fail++; $display("FAIL lrun_div(%0d): got %0d want %0d", i, DIV_CUR, e.divc); end
      if (DIV_ACK === 1'b1) DIV_LD = 1'b0;
      if (i == 1) begin
        DIV_LD = 1'b1;
        DIV_IN = 16'd7;
      end
    end
    DIV_LD = 1'b0;
  endtask

  task automatic test_stop(input bit at_pre2, input logic [15:0] exp_div);
    int n;
    if (at_pre2) begin
      n = 0;
      while (PRE !== 16'd2 && n < 100) begin cyc(); n++; end
      n_checks++; if (PRE !== 16'd2) begin n_fail++; $display("FAIL stop_wait_pre2: got %0d want 2 (timeout)", PRE); end
    end
    STOP = 1'b1;
    cyc();
    STOP = 1'b0;
    n_checks++; if (RUNNING !== 1'b0)  begin n_fail++; $display("FAIL stop_running: got %b want 0", RUNNING); end
    n_checks++; if (PRE !== 16'd0)     begin n_fail++; $display("FAIL stop_pre: got %0d want 0", PRE); end
    n_checks++; if (TICK !== 1'b0)     begin n_fail++; $display("FAIL stop_tick: got %b want 0", TICK); end
    n_checks++; if (DIV_CUR !== exp_div) begin n_fail++; $display("FAIL stop_div: got %0d want %0d", DIV_CUR, exp_div); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (PRE !== 16'd0 || TICK !== 1'b0 || RUNNING !== 1'b0) begin
        n_fail++; $display("FAIL idle_hold(%0d): got pre=%0d tick=%b run=%b want 0/0/0", i, PRE, TICK, RUNNING);
      end
    end
  endtask

  task automatic test_start_stop_both();
    START = 1'b1;
    STOP  = 1'b1;
    cyc();
    cyc();
    n_checks++; if (RUNNING !== 1'b0) begin n_fail++; $display("FAIL both_running: got %b want 0", RUNNING); end
    n_checks++; if (PRE !== 16'd0 || TICK !== 1'b0) begin n_fail++; $display("FAIL both_pre_tick: got %0d/%b want 0/0", PRE, TICK); end
    START = 1'b0;
    STOP  = 1'b0;
    cyc();
  endtask

`ifdef TICK_GEN_CTL_STEP_EN
  task automatic test_step();
    STEP = 1'b1;
    cyc();
    STEP = 1'b0;
    n_checks++; if (TICK !== 1'b1)    begin n_fail++; $display("FAIL step_tick: got %b want 1", TICK); end
    n_checks++; if (RUNNING !== 1'b0) begin n_fail++; $display("FAIL step_running: got %b want 0", RUNNING); end
    n_checks++; if (PRE !== 16'd0)    begin n_fail++; $display("FAIL step_pre: got %0d want 0", PRE); end
    cyc();
    n_checks++; if (TICK !== 1'b0)    begin n_fail++; $display("FAIL step_len: got %b want 0", TICK); end
    STEP = 1'b1;
    test_run(2, 3);
    STEP = 1'b0;
    test_stop(0, 16'd2);
  endtask
`endif

  task automatic test_reset_mid();
    test_load(16'd5, 16'd5, 16'd2);
    test_run(5, 1);
    cyc();
    cyc();
    DIV_LD = 1'b1;
    DIV_IN = 16'd9;
    cyc();
    n_checks++; if (PRE !== 16'd3 || DIV_ACK !== 1'b1) begin n_fail++; $display("FAIL rmid_setup: got pre=%0d ack=%b want 3/1", PRE, DIV_ACK); end
    DIV_LD = 1'b0;
    RST = 1'b0;
    cyc();
    RST = 1'b1;
    n_checks++; if (RUNNING !== 1'b0 || PRE !== 16'd0 || TICK !== 1'b0 || DIV_ACK !== 1'b0) begin
      n_fail++; $display("FAIL rmid_outputs: got run=%b pre=%0d tick=%b ack=%b want 0/0/0/0", RUNNING, PRE, TICK, DIV_ACK);
    end
    n_checks++; if (DIV_CUR !== 16'd50000) begin n_fail++; $display("FAIL rmid_div: got %0d want 50000", DIV_CUR); end
    for (int i = 0; i < 3; i++) cyc();
    n_checks++; if (DIV_CUR !== 16'd50000) begin n_fail++; $display("FAIL rmid_pending_dropped: got %0d want 50000", DIV_CUR); end
  endtask

  initial begin
    RST    = 1'b0;
    START  = 1'b0;
    STOP   = 1'b0;
`ifdef TICK_GEN_CTL_STEP_EN
    STEP   = 1'b0;
`endif
    DIV_LD = 1'b0;
    DIV_IN = 16'd0;

    test_reset();
    test_load(16'd5, 16'd5, 16'd50000);
    test_run(5, 3);
    test_load_in_run();
    test_stop(1, 16'd7);
    test_load(16'd0, 16'd2, 16'd7);
    test_load(16'd5, 16'd5, 16'd2);
    test_load(16'd1, 16'd2, 16'd5);
    test_run(2, 4);
    test_stop(0, 16'd2);
    test_start_stop_both();
`ifdef TICK_GEN_CTL_STEP_EN
    test_step();
`endif
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_gen_ctl.md
Name:
tick_gen_ctl

Overview:
- Clock-enable generator feeding the EN input of the mod-20 counter stages.
- Divides CLK by a runtime-programmable divisor and emits one-cycle TICK pulses.
- Provides a start/stop control FSM and a req/ack divisor-load handshake.
- Divisor changes are applied glitch-free at the terminal count, so no short or long tick period ever reaches the counters.

Parameters:
- WIDTH, 16: width of the divisor and prescaler.
- DIV_DEFAULT, 50000: active and shadow divisor after reset.
- MIN_DIV, 2: smallest legal divisor; smaller loaded values are clamped up to it.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-low.
- START  in  1  level; enter RUN.
- STOP  in  1  level; enter IDLE.
- DIV_LD  in  1  divisor load request, level.
- DIV_IN  in  WIDTH  requested divisor; must be stable while DIV_LD=1.
- DIV_ACK  out  1  one-cycle pulse; DIV_IN has been captured.
- TICK  out  1  registered one-cycle enable pulse to downstream counters.
- RUNNING  out  1  high in RUN.
- PRE  out  WIDTH  current prescaler count.
- DIV_CUR  out  WIDTH  active divisor.

Behaviour:
- Reset (RST=0 at an edge):
  - State=IDLE; PRE=0, TICK=0, DIV_ACK=0, RUNNING=0.
  - DIV_CUR=shadow=DIV_DEFAULT; pending=0.
  - Applies mid-operation too; any in-flight load is discarded.
- FSM states: IDLE, RUN.
  - IDLE -> RUN when START=1 and STOP=0. That edge sets PRE=0, TICK=0.
  - RUN -> IDLE when STOP=1. That edge sets PRE=0, TICK=0.
  - STOP wins over START when both are high.
  - START while in RUN is ignored; it does not restart the count.
- RUN counting, at every edge:
  - If PRE==DIV_CUR-1: PRE<=0, TICK<=1.
  - Else: PRE<=PRE+1, TICK<=0.
  - Tick period is exactly DIV_CUR cycles.
  - The first TICK is high in the cycle after the DIV_CUR-th edge following the START edge.
- IDLE: PRE holds 0; TICK=0.
- Divisor load handshake:
  - Accept condition: DIV_LD=1 and pending=0 and DIV_ACK=0.
  - On accept: shadow<=max(DIV_IN,MIN_DIV), pending<=1, DIV_ACK<=1 for one cycle.
  - The requester deasserts DIV_LD in the cycle it sees DIV_ACK. If DIV_LD is still high once pending clears, it is treated as a new request.
  - While pending=1, further requests stall (no ACK) until the pending value is applied.
- Divisor apply:
  - In IDLE: at the edge after accept, DIV_CUR<=shadow, pending<=0.
  - In RUN: only at a wrap edge (the PRE==DIV_CUR-1 edge), DIV_CUR<=shadow, pending<=0. The next period uses the new divisor.
  - If a RUN->IDLE transition and apply coincide, the apply still occurs.
  - Accept and apply never occur on the same edge.
- Arithmetic: PRE is unsigned WIDTH bits. It never reaches DIV_CUR because DIV_CUR>=MIN_DIV>=2, so there is no wrap-around of the WIDTH range.
- RUNNING is combinational from state.

Optional Feature:
- Macro: TICK_GEN_CTL_STEP_EN.
- With the macro defined:
  - Adds input port STEP (1 bit).
  - In IDLE with START=0 and STOP=0, STEP=1 at an edge sets TICK<=1 for exactly one cycle.
  - State stays IDLE and PRE stays 0.
  - STEP held high gives one tick per cycle.
  - STEP is ignored in RUN.
- Without the macro: no STEP port; TICK can only be produced in RUN.

Test Plan:
- Reset, then check: DIV_CUR=50000, PRE=0, TICK=0, RUNNING=0. Load DIV_IN=5 in IDLE -> DIV_ACK pulses one cycle after DIV_LD is sampled; DIV_CUR=5 one edge later.
- DIV_CUR=5, pulse START -> TICK high for one cycle every 5 cycles; first TICK 5 edges after the START edge; PRE sequence 0,1,2,3,4,0.
- RUN with DIV_CUR=5, load DIV_IN=3 while PRE=1 -> ACK immediately; period stays 5 until the wrap, then TICKs every 3 cycles. A second load during pending gets no ACK until the wrap.
- Load DIV_IN=0 and DIV_IN=1 -> DIV_CUR=2; TICK every 2 cycles in RUN.
- START and STOP high together in IDLE -> stays IDLE. STOP during RUN at PRE=2 -> IDLE next edge, PRE=0, no TICK. RST low at PRE=3 with a pending load -> all outputs at reset values and DIV_CUR=50000.
- With TICK_GEN_CTL_STEP_EN: STEP pulse in IDLE -> exactly one TICK cycle, RUNNING=0. STEP in RUN -> tick period unchanged.
